// File: rtl/adc_fixed_avg.sv
// Boxcar-averages 2^LOG2_AVG raw ADC samples and emits the mean as a signed
// fixed-point word (1.0 = 2^DEC_FORMAT) through a one-deep valid/ready register.
module adc_fixed_avg #(
    parameter int unsigned ADC_WIDTH     = 14,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEC_FORMAT    = 16,
    parameter int unsigned LOG2_AVG      = 2,
    parameter int unsigned OFFSET_BINARY = 0
) (
    input  logic                  adc_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADC_WIDTH-1:0]  adc_data,
    input  logic                  adc_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int unsigned ACC_W = ADC_WIDTH + LOG2_AVG;
    localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int unsigned SHIFT = DEC_FORMAT - (ADC_WIDTH - 1);
    localparam logic [CNT_W-1:0]     TERM     = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [ADC_WIDTH-1:0] MSB_MASK = ADC_WIDTH'(1) << (ADC_WIDTH - 1);

    logic signed [ACC_W-1:0]      acc;
    logic        [CNT_W-1:0]      cnt;
    logic signed [ADC_WIDTH-1:0]  s_c;
    logic signed [ACC_W-1:0]      sum_c;
    logic signed [ACC_W-1:0]      avg_c;
    logic signed [DATA_WIDTH-1:0] word_c;
    logic                         accept_c;
    logic                         done_c;

    // Sample conversion, running sum and scaled mean of a completing frame
    always_comb begin
        s_c      = (OFFSET_BINARY != 0) ? $signed(adc_data ^ MSB_MASK) : $signed(adc_data);
        sum_c    = acc + ACC_W'(s_c);
        avg_c    = sum_c >>> LOG2_AVG;
        word_c   = DATA_WIDTH'(avg_c) <<< SHIFT;
        accept_c = enable && adc_valid;
        done_c   = accept_c && (cnt == TERM);
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!enable || done_c) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept_c) begin
                acc <= sum_c;
                cnt <= cnt + CNT_W'(1);
            end

            // A completing frame always loads; a handshake only drains when nothing loads
            if (done_c) begin
                out_data  <= word_c;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (done_c && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_fixed_avg.md
Name: adc_fixed_avg

Overview:
- Receive-side counterpart to the fixed-point multiply / DAC output path.
- Takes raw ADC_WIDTH-bit ADC samples and averages 2^LOG2_AVG consecutive samples.
- Converts the average to the signed DATA_WIDTH-bit fixed-point word (DEC_FORMAT fractional bits) used by the SPGD datapath, where 1.0 = 2^DEC_FORMAT.
- Presents each result on a valid/ready output with a one-deep holding register and a sticky overrun flag.

Parameters:
- ADC_WIDTH, 14: raw ADC sample width.
- DATA_WIDTH, 32: output word width.
- DEC_FORMAT, 16: fractional bits of the output; must satisfy DEC_FORMAT >= ADC_WIDTH-1.
- LOG2_AVG, 2: log2 of samples per average (0..8); 0 means pass-through.
- OFFSET_BINARY, 0: 1 means the input is offset binary (MSB is inverted before use); 0 means two's complement.

Ports:
- adc_clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: averaging enable; low clears the frame in progress.
- adc_data, in, ADC_WIDTH: raw sample.
- adc_valid, in, 1: sample strobe; adc_data is sampled on an edge where adc_valid=1 and enable=1.
- out_data, out, DATA_WIDTH: fixed-point average, signed.
- out_valid, out, 1: out_data holds an unconsumed result.
- out_ready, in, 1: consumer accepts; handshake = out_valid & out_ready at the edge.
- overrun, out, 1: sticky; an unconsumed result was overwritten.
- clr_overrun, in, 1: clears overrun.

Behaviour:
- Reset (rst=1 at an edge): accumulator=0, sample counter=0, out_data=0, out_valid=0, overrun=0. Reset mid-frame discards all partial sums.
- Input conversion: s = adc_data with MSB inverted if OFFSET_BINARY=1, else adc_data as-is; s is signed.
- Accumulator: signed, ADC_WIDTH+LOG2_AVG bits; cannot overflow.
- Counter: LOG2_AVG bits, counting accepted samples 0..2^LOG2_AVG-1.
- enable=0: accumulator and counter are cleared every edge and adc_valid is ignored. out_data, out_valid and overrun are unaffected, so a pending result survives disable.
- Accepted sample, counter not at terminal value: acc <= acc + s; counter increments.
- Accepted sample, counter at terminal value (2^LOG2_AVG-1), i.e. frame complete:
  - sum = acc + s; avg = sum >>> LOG2_AVG (arithmetic shift, floor toward -inf).
  - out_data <= sign-extend(avg) << (DEC_FORMAT-(ADC_WIDTH-1)), so full-scale -2^(ADC_WIDTH-1) maps to -1.0.
  - out_valid <= 1; acc <= 0; counter <= 0 (wraps).
- Latency: out_valid rises on the same edge that captures the last sample of a frame; the result is visible the cycle after that edge. There are no bubbles; back-to-back frames are accepted every 2^LOG2_AVG valid samples.
- Handshake: if out_valid & out_ready and no frame completes at that edge, out_valid <= 0. out_data holds its value until the next load.
- Simultaneous frame completion and handshake: the new result loads, out_valid stays 1, overrun is not set.
- Frame completes while out_valid=1 and out_ready=0: the new result overwrites out_data, out_valid stays 1, overrun <= 1.
- overrun priority: set beats clr_overrun in the same cycle; otherwise clr_overrun=1 clears it.
- LOG2_AVG=0: every accepted sample produces a result; the counter is unused.
- There is no backpressure toward the ADC. The ADC stream cannot stall; dropped results are signalled only through overrun.

Test Plan:
- Two's complement, LOG2_AVG=2, out_ready=1: four samples 0x1FFF -> one out_valid pulse with out_data=0x0000FFF8; the pulse falls on the next edge.
- Four samples 0x2000 (-8192) -> out_data=0xFFFF0000 (-1.0). Samples 1,2,3,4 -> avg 2 -> 0x00000010. Samples -1,0,0,0 -> floor -1 -> 0xFFFFFFF8.
- OFFSET_BINARY=1: four samples 0x0000 -> 0xFFFF0000; four samples 0x2000 -> 0x00000000.
- out_ready=0, two full frames (values 0x0100, then 0x0200): out_data=0x00000800 then 0x00001000, overrun=1, out_valid=1. Then out_ready=1 -> out_valid=0; clr_overrun -> overrun=0.
- enable dropped after 2 of 4 samples, then 4 samples 0x0010 -> result 0x00000080, proving the partial sum was discarded. Repeat with rst pulsed mid-frame -> all outputs 0, next frame correct.
- Frame completion coincident with out_ready=1 on a pending result -> new data loaded, out_valid stays 1, overrun stays 0. Also cover adc_valid gapped every other cycle: same results, only the timing stretches.
